// File: rtl/debounce_pkg.sv
// Shared defaults and counter-mode constants for the debounced press counter.
package debounce_pkg;

    localparam int DEF_NUM_BUTTONS     = 2;
    localparam int DEF_CNT_WIDTH       = 6;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    localparam int WRAP_MODE = 1;
    localparam int SAT_MODE  = 0;

    // A single channel still needs a one-bit select port.
    function automatic int sel_width(input int num_buttons);
        return (num_buttons > 1) ? $clog2(num_buttons) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on each accepted press.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_button,
    output logic o_stable,
    output logic o_press_pulse,
    output logic o_rise
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_stable;
    logic            r_press_pulse;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_stable);
    assign w_accept = w_differ && (r_db_cnt == DB_LAST);

    // NOTE: every register here uses <= so all flops sample pre-edge values;
    // blocking assignments would collapse the two synchronizer stages into one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_db_cnt      <= '0;
            r_stable      <= 1'b0;
            r_press_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;

            // Any sample that agrees with the accepted level restarts the count.
            if (!w_differ || w_accept) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end

            if (w_accept) begin
                r_stable <= r_sync2;
            end

            r_press_pulse <= w_accept && r_sync2;
        end
    end

    assign o_stable      = r_stable;
    assign o_press_pulse = r_press_pulse;
    assign o_rise        = w_accept && r_sync2;

endmodule

// File: rtl/debounced_press_counter.sv
// Multi-channel debounced button press counter with a registered LED view of
// the selected channel's count.
module debounced_press_counter
    import debounce_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WRAP            = WRAP_MODE
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_BUTTONS-1:0]              buttons,
    input  logic [NUM_BUTTONS-1:0]              clear,
    input  logic [sel_width(NUM_BUTTONS)-1:0]   sel,
    output logic [CNT_WIDTH-1:0]                leds,
    output logic [NUM_BUTTONS-1:0]              stable,
    output logic [NUM_BUTTONS-1:0]              press_pulse
);

    localparam int                   SEL_W     = sel_width(NUM_BUTTONS);
    localparam int                   SEL_SLOTS = 1 << SEL_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [NUM_BUTTONS-1:0] w_rise;
    logic [CNT_WIDTH-1:0]   w_count_slot [SEL_SLOTS];
    logic [CNT_WIDTH-1:0]   r_leds;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] r_count;

        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clock         (clock),
            .reset_n       (reset_n),
            .i_button      (buttons[g]),
            .o_stable      (stable[g]),
            .o_press_pulse (press_pulse[g]),
            .o_rise        (w_rise[g])
        );

        // Clear has priority over a press accepted on the same edge.
        always_ff @(posedge clock) begin
            if (!reset_n || clear[g]) begin
                r_count <= '0;
            end else if (w_rise[g]) begin
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + CNT_ONE;
                end else if (WRAP == WRAP_MODE) begin
                    r_count <= '0;
                end
            end
        end

        assign w_count_slot[g] = r_count;
    end

    // NOTE: the mux is padded to a full power-of-two table so an out-of-range
    // select reads a hard zero instead of indexing past the channel array.
    for (genvar g = NUM_BUTTONS; g < SEL_SLOTS; g++) begin : g_pad
        assign w_count_slot[g] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_count_slot[sel];
        end
    end

    assign leds = r_leds;

endmodule

// File: tb/tb_debounced_press_counter.sv
// Scoreboard bench: three configurations (wrap, saturate, three channels) share
// stimulus; a window-based reference model predicts every cycle's outputs.
module tb_debounced_press_counter;

    localparam int D  = 4;
    localparam int CW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] buttons3 = '0;
    logic [2:0] clear3 = '0;
    logic [1:0] sel3 = '0;

    logic [CW-1:0] leds_w, leds_s, leds3;
    logic [1:0]    stable_w, pulse_w, stable_s, pulse_s;
    logic [2:0]    stable3, pulse3;

    always #5 clk = ~clk;

    debounced_press_counter #(.NUM_BUTTONS(2), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(D), .WRAP(1)) dut_wrap (
        .clock(clk), .reset_n(rst_n), .buttons(buttons3[1:0]), .clear(clear3[1:0]),
        .sel(sel3[0]), .leds(leds_w), .stable(stable_w), .press_pulse(pulse_w));

    debounced_press_counter #(.NUM_BUTTONS(2), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(D), .WRAP(0)) dut_sat (
        .clock(clk), .reset_n(rst_n), .buttons(buttons3[1:0]), .clear(clear3[1:0]),
        .sel(sel3[0]), .leds(leds_s), .stable(stable_s), .press_pulse(pulse_s));

    debounced_press_counter #(.NUM_BUTTONS(3), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(D), .WRAP(1)) dut_three (
        .clock(clk), .reset_n(rst_n), .buttons(buttons3), .clear(clear3),
        .sel(sel3), .leds(leds3), .stable(stable3), .press_pulse(pulse3));

    typedef struct packed {
        logic [2:0]         st;
        logic [2:0]         pp;
        logic [2:0][CW-1:0] ld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: hist[c][k] is the button level sampled k edges ago.
    bit [63:0] hist [3];
    bit        m_stable [3];
    bit        m_pulse [3];
    int        m_cnt [3][3];
    int        m_leds [3];

    function automatic int nb_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic bit wrap_of(input int d);
        return d != 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rise [3];
        int s;
        bit all_diff;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                hist[c] = '0;
                m_stable[c] = 1'b0;
                m_pulse[c] = 1'b0;
                for (int d = 0; d < 3; d++) m_cnt[d][c] = 0;
            end
            for (int d = 0; d < 3; d++) m_leds[d] = 0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                s = (d == 2) ? int'(sel3) : int'(sel3[0]);
                m_leds[d] = (s < nb_of(d)) ? m_cnt[d][s] : 0;
            end
            for (int c = 0; c < 3; c++) begin
                hist[c] = {hist[c][62:0], buttons3[c]};
                // The synchronized level seen at this edge was sampled two edges ago;
                // a change is accepted after D consecutive disagreeing samples.
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[c][2+j] == m_stable[c]) all_diff = 1'b0;
                rise[c] = all_diff && !m_stable[c];
                if (all_diff) m_stable[c] = !m_stable[c];
                m_pulse[c] = rise[c];
            end
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < nb_of(d); c++) begin
                    if (clear3[c]) m_cnt[d][c] = 0;
                    else if (rise[c])
                        m_cnt[d][c] = wrap_of(d) ? (m_cnt[d][c] + 1) % 64
                                                 : ((m_cnt[d][c] + 1 > 63) ? 63 : m_cnt[d][c] + 1);
                end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            e.st[c] = m_stable[c];
            e.pp[c] = m_pulse[c];
            e.ld[c] = CW'(m_leds[c]);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        sb.push_back(snapshot());
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_stable_wrap", 32'(stable_w), 32'(e.st[1:0]));
                check("sb_pulse_wrap",  32'(pulse_w),  32'(e.pp[1:0]));
                check("sb_leds_wrap",   32'(leds_w),   32'(e.ld[0]));
                check("sb_stable_sat",  32'(stable_s), 32'(e.st[1:0]));
                check("sb_pulse_sat",   32'(pulse_s),  32'(e.pp[1:0]));
                check("sb_leds_sat",    32'(leds_s),   32'(e.ld[1]));
                check("sb_stable_three", 32'(stable3), 32'(e.st));
                check("sb_pulse_three",  32'(pulse3),  32'(e.pp));
                check("sb_leds_three",   32'(leds3),   32'(e.ld[2]));
            end
        end
    end

    initial begin
        int  n;
        bit  saw;
        int  rate;

        // Reset state
        rst_n = 1'b0;
        steps(3);
        check("reset_stable", 32'(stable3), 32'd0);
        check("reset_pulse",  32'(pulse3),  32'd0);
        check("reset_leds",   32'(leds_w),  32'd0);
        rst_n = 1'b1;

        // Held press: stable after edge 6, pulse on edge 6 only, leds after edge 7
        buttons3 = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("hold_stable", 32'(stable_w[0]), 32'(k >= 6));
            check("hold_pulse",  32'(pulse_w[0]),  32'(k == 6));
            check("hold_leds",   32'(leds_w),      (k >= 7) ? 32'd1 : 32'd0);
        end
        buttons3 = 3'b000;
        steps(10);

        // Bounce every 3 cycles is never accepted
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            buttons3[0] = ((i / 3) % 2) != 0;
            step();
            saw = saw | stable_w[0];
        end
        check("bounce_stable", 32'(saw), 32'd0);
        check("bounce_leds",   32'(leds_w), 32'd1);
        buttons3 = 3'b000;
        steps(10);

        // Clear on the accepting edge wins, pulse still fires
        buttons3 = 3'b001;
        steps(5);
        clear3 = 3'b001;
        step();
        check("clear_pulse", 32'(pulse_w[0]), 32'd1);
        clear3 = 3'b000;
        step();
        check("clear_pulse_end", 32'(pulse_w[0]), 32'd0);
        check("clear_leds", 32'(leds_w), 32'd0);
        buttons3 = 3'b000;
        steps(10);

        // Reset mid-debounce, then the full latency applies again
        buttons3 = 3'b001;
        steps(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (stable_w[0] && n == 0) n = k;
        end
        check("reset_latency", 32'(n), 32'd6);
        check("reset_press_count", 32'(leds_w), 32'd1);
        buttons3 = 3'b000;
        steps(10);

        // 64 presses on channel 1: wrap gives 0, saturate gives 63
        clear3 = 3'b111;
        step();
        clear3 = 3'b000;
        sel3 = 2'd1;
        for (int p = 0; p < 64; p++) begin
            buttons3[1] = 1'b1;
            steps(8);
            buttons3[1] = 1'b0;
            steps(8);
        end
        step();
        check("wrap_count", 32'(leds_w), 32'd0);
        check("sat_count",  32'(leds_s), 32'd63);

        // Simultaneous presses and select handling
        clear3 = 3'b111;
        step();
        clear3 = 3'b000;
        buttons3 = 3'b111;
        steps(8);
        buttons3 = 3'b000;
        steps(8);
        sel3 = 2'd0;
        steps(2);
        check("both_sel0_wrap",  32'(leds_w), 32'd1);
        check("both_sel0_three", 32'(leds3),  32'd1);
        sel3 = 2'd1;
        steps(2);
        check("both_sel1_wrap", 32'(leds_w), 32'd1);
        check("both_sel1_sat",  32'(leds_s), 32'd1);
        sel3 = 2'd3;
        steps(2);
        check("sel_out_of_range", 32'(leds3), 32'd0);

        // Randomized bouncing, clears, select changes and occasional resets
        for (int blk = 0; blk < 12; blk++) begin
            rate = $urandom_range(12, 1);
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < 3; c++)
                    if ($urandom_range(rate, 0) == 0) buttons3[c] = ~buttons3[c];
                clear3 = '0;
                for (int c = 0; c < 3; c++)
                    if ($urandom_range(40, 0) == 0) clear3[c] = 1'b1;
                if ($urandom_range(3, 0) == 0) sel3 = 2'($urandom_range(3, 0));
                rst_n = ($urandom_range(499, 0) != 0);
                step();
            end
        end
        rst_n = 1'b1;
        clear3 = '0;

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounced_press_counter.md
DEBOUNCED_PRESS_COUNTER -- requirements
Module: debounced_press_counter

Interface
REQ-001 Parameter: NUM_BUTTONS, default 2, number of independent button channels (1..8).
REQ-002 Parameter: CNT_WIDTH, default 6, width of each per-channel press counter and of leds.
REQ-003 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a level change (>=2).
REQ-004 Parameter: WRAP, default 1, 1 = counter wraps at max, 0 = counter saturates at max.
REQ-005 Port: clock, input, 1, single clock; all state SHALL change only on its rising edge.
REQ-006 Port: reset_n, input, 1, synchronous active-low reset.
REQ-007 Port: buttons, input, NUM_BUTTONS, raw asynchronous bouncing button levels, active high.
REQ-008 Port: clear, input, NUM_BUTTONS, synchronous per-channel counter clear, active high.
REQ-009 Port: sel, input, max(1,$clog2(NUM_BUTTONS)), channel whose count is shown on leds.
REQ-010 Port: leds, output, CNT_WIDTH, registered count of channel sel.
REQ-011 Port: stable, output, NUM_BUTTONS, debounced level per channel.
REQ-012 Port: press_pulse, output, NUM_BUTTONS, one-cycle pulse per accepted rising edge.

Function
REQ-013 Each channel SHALL pass buttons[i] through a two-flop synchronizer before any other use.
REQ-014 Each channel SHALL hold a debounce counter, cleared whenever synchronized level equals stable[i].
REQ-015 While synchronized level differs from stable[i], the debounce counter SHALL increment each cycle; when it reaches DEBOUNCE_CYCLES-1 and the level still differs, stable[i] SHALL take the synchronized level on that edge and the counter SHALL clear.
REQ-016 A single-cycle disagreement SHALL clear the debounce counter (glitch shorter than DEBOUNCE_CYCLES is never accepted).
REQ-017 Latency: buttons[i] rising and held SHALL raise stable[i] exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it high.
REQ-018 press_pulse[i] SHALL be high for exactly the one cycle following the edge at which stable[i] goes 0->1; no pulse on 1->0.
REQ-019 The per-channel press count SHALL increment on the same edge stable[i] goes 0->1.
REQ-020 At count = 2^CNT_WIDTH-1 with an accepted press: WRAP=1 -> count becomes 0; WRAP=0 -> count holds.
REQ-021 clear[i] high SHALL set count[i] to 0 on that edge; clear SHALL win over a simultaneous increment; press_pulse[i] still fires.
REQ-022 leds SHALL equal count[sel] registered, i.e. one cycle after count or sel changes.
REQ-023 sel >= NUM_BUTTONS SHALL drive leds to 0.
REQ-024 Channels SHALL be fully independent; simultaneous presses on all channels SHALL each be counted.

Reset
REQ-025 reset_n low at a rising edge SHALL clear synchronizers, debounce counters, stable, press_pulse, counts and leds to 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; after release a held-high button SHALL need the full DEBOUNCE_CYCLES+2 edges and SHALL then count as one press.

Structure
REQ-027 Package debounce_pkg SHALL hold default parameter constants and the mode constants WRAP_MODE=1, SAT_MODE=0.
REQ-028 Sub-module debounce_channel (synchronizer, debounce counter, stable, press_pulse) SHALL be instantiated once per channel via generate; counters and leds mux live in the top block.

Verification (NUM_BUTTONS=2, CNT_WIDTH=6, DEBOUNCE_CYCLES=4)
REQ-029 Hold buttons[0]=1 from edge 1 -> stable[0]=1 and count0=1 after edge 6, press_pulse[0] high one cycle, leds=1 after edge 7 with sel=0.
REQ-030 Toggle buttons[0] every 3 cycles for 60 cycles -> stable[0] stays 0, count0 stays 0.
REQ-031 WRAP=1, 64 clean presses on ch1 -> count1 = 0; WRAP=0 same stimulus -> count1 = 63.
REQ-032 clear[0]=1 on the same edge a press is accepted -> count0 = 0, press_pulse[0] = 1 for one cycle.
REQ-033 reset_n=0 for one edge after 2 cycles of a held press, then release -> stable[0] rises 6 edges after release, count0 = 1.
REQ-034 Both buttons pressed together, sel switched 0->1 -> count0=count1=1, leds=1 for both selections, sel=3 (width 1 excludes; use NUM_BUTTONS=3, sel=3) -> leds=0.
